// File: rtl/text_pkg.sv
// Shared definitions for the character text path: ASCII codes, writer
// states and default screen geometry.
package text_pkg;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_FF     = 8'h0C;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLR_LINE = 2'd1,
        ST_CLR_ALL  = 2'd2
    } state_e;

endpackage

// File: rtl/text_cursor.sv
// Text cursor: column/row position plus the base address of the current row,
// maintained incrementally so no multiplier is needed to form RAM addresses.
module text_cursor #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int ADDR_SIZE = 12,
    parameter int COL_W     = $clog2(COLS),
    parameter int ROW_W     = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance_i,
    input  logic                 newline_i,
    input  logic                 backspace_i,
    input  logic                 home_i,
    output logic [COL_W-1:0]     col_o,
    output logic [ROW_W-1:0]     row_o,
    output logic [ADDR_SIZE-1:0] row_base_o
);

    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [ADDR_SIZE-1:0] base_q, base_d;
    logic                 row_step;

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        base_d   = base_q;
        row_step = 1'b0;
        if (home_i) begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
        end else if (newline_i) begin
            col_d    = '0;
            row_step = 1'b1;
        end else if (advance_i) begin
            if (col_q == COL_W'(COLS - 1)) begin
                col_d    = '0;
                row_step = 1'b1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else if (backspace_i && (col_q != '0)) begin
            col_d = col_q - COL_W'(1);
        end

        // Bottom row wraps to the top; backspace never wraps upward.
        if (row_step) begin
            if (row_q == ROW_W'(ROWS - 1)) begin
                row_d  = '0;
                base_d = '0;
            end else begin
                row_d  = row_q + ROW_W'(1);
                base_d = base_q + ADDR_SIZE'(COLS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

    assign col_o      = col_q;
    assign row_o      = row_q;
    assign row_base_o = base_q;

endmodule

// File: rtl/text_buffer_writer.sv
// Character stream to text RAM writer: interprets printable and control bytes,
// tracks the cursor and sweeps line / full-screen clears through the write port.
module text_buffer_writer
    import text_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 12,
    parameter int COLS      = DEFAULT_COLS,
    parameter int ROWS      = DEFAULT_ROWS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_SIZE-1:0]     in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     we,
    output logic [ADDR_SIZE-1:0]     addr_a,
    output logic [DATA_SIZE-1:0]     din_a,
    output logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic                     busy,
    output logic [1:0]               dbg_state_o
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int TOTAL = COLS * ROWS;
    localparam logic [ADDR_SIZE-1:0] LINE_LAST   = ADDR_SIZE'(COLS - 1);
    localparam logic [ADDR_SIZE-1:0] SCREEN_LAST = ADDR_SIZE'(TOTAL - 1);
    localparam logic [DATA_SIZE-1:0] SPACE       = DATA_SIZE'(CH_SPACE);

    state_e               state_q;
    logic [ADDR_SIZE-1:0] clr_cnt_q;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0] din_q;

    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [ADDR_SIZE-1:0] row_base;
    logic [ADDR_SIZE-1:0] cur_addr;
    logic                 accept, is_print, is_nl, is_bs, is_ff;
    logic                 at_last_col, col_zero;
    logic                 adv, nl, bs, home;

    // valid/ready: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE and the upstream holds in_data while it is low.
    assign accept   = in_valid && (state_q == ST_IDLE);
    assign is_print = (in_data >= DATA_SIZE'(PRINT_MIN)) && (in_data <= DATA_SIZE'(PRINT_MAX));
    assign is_nl    = (in_data == DATA_SIZE'(CH_LF)) || (in_data == DATA_SIZE'(CH_CR));
    assign is_bs    = (in_data == DATA_SIZE'(CH_BS));
    assign is_ff    = (in_data == DATA_SIZE'(CH_FF));

    assign at_last_col = (col == COL_W'(COLS - 1));
    assign col_zero    = (col == '0);
    assign cur_addr    = row_base + ADDR_SIZE'(col);

    assign adv  = accept && is_print;
    assign nl   = accept && is_nl;
    assign bs   = accept && is_bs && !col_zero;
    assign home = (state_q == ST_CLR_ALL) && (clr_cnt_q == SCREEN_LAST);

    text_cursor #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_cursor (
        .clk         (clk),
        .reset       (reset),
        .advance_i   (adv),
        .newline_i   (nl),
        .backspace_i (bs),
        .home_i      (home),
        .col_o       (col),
        .row_o       (row),
        .row_base_o  (row_base)
    );

    // The clear counter is zero whenever the FSM sits in IDLE, so entering a
    // clear needs no extra initialisation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_CLR_ALL;
            clr_cnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (adv) begin
                        we_q   <= 1'b1;
                        addr_q <= cur_addr;
                        din_q  <= in_data;
                        if (at_last_col) state_q <= ST_CLR_LINE;
                    end else if (nl) begin
                        state_q <= ST_CLR_LINE;
                    end else if (bs) begin
                        we_q   <= 1'b1;
                        addr_q <= cur_addr - ADDR_SIZE'(1);
                        din_q  <= SPACE;
                    end else if (accept && is_ff) begin
                        state_q <= ST_CLR_ALL;
                    end
                end
                ST_CLR_LINE: begin
                    we_q   <= 1'b1;
                    addr_q <= row_base + clr_cnt_q;
                    din_q  <= SPACE;
                    if (clr_cnt_q == LINE_LAST) begin
                        clr_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_SIZE'(1);
                    end
                end
                ST_CLR_ALL: begin
                    we_q   <= 1'b1;
                    addr_q <= clr_cnt_q;
                    din_q  <= SPACE;
                    if (clr_cnt_q == SCREEN_LAST) begin
                        clr_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_SIZE'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_CLR_LINE) || (state_q == ST_CLR_ALL);
    assign we          = we_q;
    assign addr_a      = addr_q;
    assign din_a       = din_q;
    assign cursor_row  = row;
    assign cursor_col  = col;
    assign dbg_state_o = state_q;

endmodule
